// File: rtl/pipelined_addsub_rca_if.sv
// rtl/pipelined_addsub_rca_if.sv - operand/result handshake bundle for the pipelined add/sub unit

interface pipelined_addsub_rca_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, sub, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, sub, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub_rca.sv
// rtl/pipelined_addsub_rca.sv - pipelined ripple-carry add/subtract, one CHUNK-bit slice per stage

module pipelined_addsub_rca #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipelined_addsub_rca_if.slave   bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Whole pipe moves together; it only holds when a finished result is refused.
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage registers: operands ride along (input skew) and finished low
    // chunks accumulate in s_q (output de-skew) so all bits leave together.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              ovf_q;
    logic              zero_q;

    logic [STAGES-1:0] v_n;
    logic [STAGES-1:0] c_n;
    logic [WIDTH-1:0]  a_n [STAGES];
    logic [WIDTH-1:0]  b_n [STAGES];
    logic [WIDTH-1:0]  s_n [STAGES];
    logic              ovf_n;
    logic              zero_n;

    assign adv          = bus.out_ready | ~v_q[LAST];
    assign bus.in_ready = adv;

    // Subtraction is a + ~b + 1, so the mode folds into B and the carry-in.
    assign b_eff   = bus.b ^ {WIDTH{bus.sub}};
    assign cin_eff = bus.sub | bus.cin;

    // Ripple one chunk (chunk index k) into a copy of the partial sum; returns {carry, sum}.
    function automatic logic [WIDTH:0] add_chunk(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] s_prev,
        input logic             c_in,
        input int               k
    );
        logic [WIDTH-1:0] sum;
        logic             c;
        logic [IW-1:0]    idx;
        sum = s_prev;
        c   = c_in;
        for (int i = 0; i < CHUNK; i++) begin
            idx      = IW'(k * CHUNK + i);
            sum[idx] = x[idx] ^ y[idx] ^ c;
            c        = (x[idx] & y[idx]) | (c & (x[idx] ^ y[idx]));
        end
        return {c, sum};
    endfunction

    // Next-state of every slice: stage 0 takes the bus, stage k takes stage k-1.
    always_comb begin
        v_n[0]            = bus.in_valid;
        a_n[0]            = bus.a;
        b_n[0]            = b_eff;
        {c_n[0], s_n[0]}  = add_chunk(bus.a, b_eff, '0, cin_eff, 0);
        for (int k = 1; k < STAGES; k++) begin
            v_n[k]           = v_q[k-1];
            a_n[k]           = a_q[k-1];
            b_n[k]           = b_q[k-1];
            {c_n[k], s_n[k]} = add_chunk(a_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], k);
        end
        // Carry into the MSB is recovered as a ^ b ^ s at that bit.
        ovf_n  = c_n[LAST] ^ a_n[LAST][WIDTH-1] ^ b_n[LAST][WIDTH-1] ^ s_n[LAST][WIDTH-1];
        zero_n = (s_n[LAST] == '0);
    end

    // Stage registers and output flags; everything shifts on adv, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q    <= v_n;
            c_q    <= c_n;
            ovf_q  <= ovf_n;
            zero_q <= zero_n;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_n[k];
                b_q[k] <= b_n[k];
                s_q[k] <= s_n[k];
            end
        end
    end

    assign bus.out_valid = v_q[LAST];
    assign bus.s         = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub_rca.sv
// tb/tb_pipelined_addsub_rca.sv - bench for pipelined_addsub_rca at CHUNK 1, 4 and 16

module tb_pipelined_addsub_rca;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        sub;
    logic        cin;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;

    int n_chk;
    int n_err;
    int cyc;
    bit lat_en;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t sb [3][64];
    int   hd [3];
    int   tl [3];

    pipelined_addsub_rca_if #(.WIDTH(16)) if_c1  ();
    pipelined_addsub_rca_if #(.WIDTH(16)) if_c4  ();
    pipelined_addsub_rca_if #(.WIDTH(16)) if_c16 ();

    assign if_c1.in_valid   = in_valid;
    assign if_c1.sub        = sub;
    assign if_c1.a          = a;
    assign if_c1.b          = b;
    assign if_c1.cin        = cin;
    assign if_c1.out_ready  = out_ready;
    assign if_c4.in_valid   = in_valid;
    assign if_c4.sub        = sub;
    assign if_c4.a          = a;
    assign if_c4.b          = b;
    assign if_c4.cin        = cin;
    assign if_c4.out_ready  = out_ready;
    assign if_c16.in_valid  = in_valid;
    assign if_c16.sub       = sub;
    assign if_c16.a         = a;
    assign if_c16.b         = b;
    assign if_c16.cin       = cin;
    assign if_c16.out_ready = out_ready;

    pipelined_addsub_rca #(.WIDTH(16), .CHUNK(1))  dut_c1  (.clk(clk), .rst_n(rst_n), .bus(if_c1.slave));
    pipelined_addsub_rca #(.WIDTH(16), .CHUNK(4))  dut_c4  (.clk(clk), .rst_n(rst_n), .bus(if_c4.slave));
    pipelined_addsub_rca #(.WIDTH(16), .CHUNK(16)) dut_c16 (.clk(clk), .rst_n(rst_n), .bus(if_c16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %04h expected %04h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string nm, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Golden model: plain integer arithmetic on the unsigned and signed views.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic sb_, input logic ci, input int acc);
        exp_t e;
        int   ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb_) begin
            r   = ux - uy;
            sr  = sx - sy;
            e.c = (ux >= uy);
        end else begin
            r   = ux + uy + (ci ? 1 : 0);
            sr  = sx + sy + (ci ? 1 : 0);
            e.c = (r > 65535);
        end
        e.s    = r[15:0];
        e.o    = (sr > 32767) || (sr < -32768);
        e.z    = (e.s == 16'h0000);
        e.acc  = acc;
        e.seen = 1'b0;
        return e;
    endfunction

    // Scoreboard step for one DUT, evaluated once per cycle away from the clock edge.
    task automatic cmp(input int d, input int stages, input logic ov, input logic ir,
                       input logic [15:0] s_o, input logic c_o, input logic o_o, input logic z_o);
        exp_t e;
        if (ov) begin
            if (hd[d] == tl[d]) begin
                n_chk = n_chk + 1;
                n_err = n_err + 1;
                $display("FAIL dut%0d_spurious: got out_valid=1 expected no result pending (cycle %0d)", stages, cyc);
            end else begin
                e = sb[d][hd[d] % 64];
                chk16($sformatf("dut%0d_s", stages), s_o, e.s);
                chk1($sformatf("dut%0d_cout", stages), c_o, e.c);
                chk1($sformatf("dut%0d_ovf", stages), o_o, e.o);
                chk1($sformatf("dut%0d_zero", stages), z_o, e.z);
                if (!e.seen) begin
                    if (lat_en) chk32($sformatf("dut%0d_latency", stages), cyc - e.acc, stages);
                    sb[d][hd[d] % 64].seen = 1'b1;
                end
                if (out_ready) hd[d] = hd[d] + 1;
            end
        end
        if (in_valid && ir) begin
            sb[d][tl[d] % 64] = model(a, b, sub, cin, cyc);
            tl[d] = tl[d] + 1;
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            hd[d] = 0;
            tl[d] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int d = 0; d < 3; d++) hd[d] = tl[d];
            end else begin
                cmp(0, 16, if_c1.out_valid, if_c1.in_ready, if_c1.s, if_c1.cout, if_c1.ovf, if_c1.zero);
                cmp(1, 4, if_c4.out_valid, if_c4.in_ready, if_c4.s, if_c4.cout, if_c4.ovf, if_c4.zero);
                cmp(2, 1, if_c16.out_valid, if_c16.in_ready, if_c16.s, if_c16.cout, if_c16.ovf, if_c16.zero);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One op through the CHUNK=4 unit: nothing at cycle 3 after accept, result at cycle 4.
    task automatic run_one(input string nm, input logic [15:0] x, input logic [15:0] y,
                           input logic sb_, input logic ci, input logic [15:0] es,
                           input logic ec, input logic eo, input logic ez);
        a = x; b = y; sub = sb_; cin = ci; in_valid = 1'b1;
        @(negedge clk);
        chk1({nm, "_in_ready"}, if_c4.in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1({nm, "_early"}, if_c4.out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1({nm, "_valid"}, if_c4.out_valid, 1'b1);
        chk16({nm, "_s"}, if_c4.s, es);
        chk1({nm, "_cout"}, if_c4.cout, ec);
        chk1({nm, "_ovf"}, if_c4.ovf, eo);
        chk1({nm, "_zero"}, if_c4.zero, ez);
        @(posedge clk); #1;
    endtask

    logic [15:0] bp_exp [3];
    logic [15:0] pins_a [6];
    logic [15:0] pins_b [6];
    exp_t        pm;
    int          seen_cnt;

    initial begin
        n_chk = 0; n_err = 0; lat_en = 1'b1;
        rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        a = 16'h0; b = 16'h0;

        // Pin the model with hand-computed results.
        pm = model(16'h1234, 16'h0FCD, 1'b0, 1'b1, 0);
        chk16("model_add_s", pm.s, 16'h2202);
        chk1("model_add_cout", pm.c, 1'b0);
        pm = model(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
        chk16("model_wrap_s", pm.s, 16'h0000);
        chk1("model_wrap_cout", pm.c, 1'b1);
        chk1("model_wrap_zero", pm.z, 1'b1);
        pm = model(16'h8000, 16'h0001, 1'b1, 1'b0, 0);
        chk16("model_sub_s", pm.s, 16'h7FFF);
        chk1("model_sub_ovf", pm.o, 1'b1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset_out_valid", if_c4.out_valid, 1'b0);
        chk16("reset_s", if_c4.s, 16'h0000);
        chk1("reset_cout", if_c4.cout, 1'b0);
        chk1("reset_ovf", if_c4.ovf, 1'b0);
        chk1("reset_zero", if_c4.zero, 1'b0);
        chk1("reset_in_ready", if_c4.in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        run_one("first_op", 16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2202, 1'b0, 1'b0, 1'b0);
        run_one("ripple_all", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        idle(20);

        // Back-to-back stream: a=i, b=3i -> s=4i on consecutive cycles.
        for (int j = 0; j < 13; j++) begin
            in_valid = (j < 8);
            a = 16'(j); b = 16'(3 * j); sub = 1'b0; cin = 1'b0;
            @(negedge clk);
            if (j < 8) chk1("stream_in_ready", if_c4.in_ready, 1'b1);
            if (j >= 4 && j < 12) begin
                chk1("stream_valid", if_c4.out_valid, 1'b1);
                chk16("stream_s", if_c4.s, 16'(4 * (j - 4)));
            end else begin
                chk1("stream_gap", if_c4.out_valid, 1'b0);
            end
            @(posedge clk); #1;
        end
        idle(20);

        // Back-pressure: 3 ops in flight, consumer refuses for 5 cycles.
        lat_en = 1'b0;
        bp_exp[0] = 16'h0111; bp_exp[1] = 16'h00DF; bp_exp[2] = 16'h0135;
        for (int j = 0; j < 14; j++) begin
            in_valid  = (j < 3);
            a         = 16'h0100 + 16'(j);
            b         = 16'h0011 * 16'(j + 1);
            sub       = (j == 1);
            cin       = 1'b0;
            out_ready = !(j >= 3 && j < 9);
            @(negedge clk);
            if (j >= 4 && j < 9) begin
                chk1("bp_hold_valid", if_c4.out_valid, 1'b1);
                chk16("bp_hold_s", if_c4.s, bp_exp[0]);
                chk1("bp_in_ready", if_c4.in_ready, 1'b0);
            end
            if (j >= 9 && j < 12) begin
                chk1("bp_drain_valid", if_c4.out_valid, 1'b1);
                chk16("bp_drain_s", if_c4.s, bp_exp[j - 9]);
            end
            if (j == 12) chk1("bp_drain_done", if_c4.out_valid, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        idle(20);

        // Reset while two ops are in flight and one is stalled at the output.
        for (int j = 0; j < 5; j++) begin
            in_valid  = (j < 2);
            a         = (j == 0) ? 16'h0005 : 16'h0009;
            b         = (j == 0) ? 16'h0003 : 16'h0002;
            sub       = 1'b0;
            cin       = 1'b0;
            out_ready = (j < 2);
            @(negedge clk);
            if (j == 4) begin
                chk1("pre_reset_valid", if_c4.out_valid, 1'b1);
                chk16("pre_reset_s", if_c4.s, 16'h0008);
            end
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_reset_valid", if_c4.out_valid, 1'b0);
        chk16("async_reset_s", if_c4.s, 16'h0000);
        chk1("async_reset_in_ready", if_c4.in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen_cnt = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (if_c4.out_valid || if_c1.out_valid || if_c16.out_valid) seen_cnt = seen_cnt + 1;
        end
        chk32("post_reset_stale", seen_cnt, 0);
        @(posedge clk); #1;

        // Sweep all three chunk sizes with edge and random operands, no back-pressure.
        lat_en = 1'b1;
        pins_a[0] = 16'hFFFF; pins_b[0] = 16'h0001;
        pins_a[1] = 16'h7FFF; pins_b[1] = 16'h0001;
        pins_a[2] = 16'h8000; pins_b[2] = 16'h8000;
        pins_a[3] = 16'h0000; pins_b[3] = 16'h0000;
        pins_a[4] = 16'hFFFF; pins_b[4] = 16'hFFFF;
        pins_a[5] = 16'h8000; pins_b[5] = 16'h7FFF;
        for (int j = 0; j < 60; j++) begin
            if (j < 12) begin
                a = pins_a[j % 6]; b = pins_b[j % 6]; sub = (j >= 6); cin = j[0];
                in_valid = 1'b1;
            end else begin
                a = 16'($urandom); b = 16'($urandom);
                sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
        end
        idle(20);

        // Random back-pressure on top of random traffic.
        lat_en = 1'b0;
        for (int j = 0; j < 80; j++) begin
            a = 16'($urandom); b = 16'($urandom);
            sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        idle(25);

        chk32("c1_drained", tl[0] - hd[0], 0);
        chk32("c4_drained", tl[1] - hd[1], 0);
        chk32("c16_drained", tl[2] - hd[2], 0);
        chk1("sweep_produced", (hd[0] > 40) && (hd[1] > 40) && (hd[2] > 40), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
